// File: rtl/edm_pkg.sv
// edm_pkg: shared encodings and saturation helper for the EDM discharge monitor
package edm_pkg;
  typedef enum logic [1:0] {
    PT_OPEN   = 2'd0,
    PT_NORMAL = 2'd1,
    PT_ARC    = 2'd2,
    PT_SHORT  = 2'd3
  } pulse_type_t;
  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_WAIT   = 4'b0010,
    S_ON     = 4'b0100,
    S_REPORT = 4'b1000
  } state_t;
  localparam logic [15:0] SAT16 = 16'hFFFF;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == SAT16) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit saturating event counter, clear beats increment
module sat_counter16
  import edm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);
  // count up on inc, stick at all-ones, clear wins over a coincident inc
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= sat_inc(cnt);
endmodule

// File: rtl/discharge_state_detect.sv
// discharge_state_detect: classifies each EDM discharge frame and reports timing, peak and statistics
module discharge_state_detect
  import edm_pkg::*;
#(
  parameter logic        [15:0] BREAKDOWN_THRESHOLD_CUR = 16'd10,
  parameter logic signed [16:0] BREAKDOWN_THRESHOLD_VOL = 17'sd30,
  parameter logic        [15:0] ARC_DELAY_MAX           = 16'd50,
  parameter logic        [15:0] SHORT_DELAY_MAX         = 16'd3,
  parameter logic signed [16:0] SHORT_VOL_TH            = 17'sd5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               monitor_en,
  input  logic               mosfet_deion,
  input  logic signed [16:0] sample_current,
  input  logic signed [16:0] sample_voltage,
  input  logic               stat_clear,
  output logic               pulse_valid,
  output logic [1:0]         pulse_type,
  output logic [15:0]        ignition_delay,
  output logic [15:0]        on_time,
  output logic [15:0]        peak_current,
  output logic [15:0]        cnt_open,
  output logic [15:0]        cnt_normal,
  output logic [15:0]        cnt_arc,
  output logic [15:0]        cnt_short
);
  logic               deion_d;
  logic signed [16:0] cur_d, vol_d, v_bd;
  logic [15:0]        dly, ont, peak;
  state_t             state, state_nx;
  pulse_type_t        ptype, cls;
  logic               fall, rise, bd, rep;
  assign fall = deion_d & ~mosfet_deion;
  assign rise = ~deion_d & mosfet_deion;
  assign bd   = (cur_d >= $signed({1'b0, BREAKDOWN_THRESHOLD_CUR})) && (vol_d < BREAKDOWN_THRESHOLD_VOL);
  assign rep  = monitor_en && state == S_REPORT;
  assign cls  = (dly <= SHORT_DELAY_MAX && v_bd < SHORT_VOL_TH) ? PT_SHORT :
                (dly <= ARC_DELAY_MAX) ? PT_ARC : PT_NORMAL;
  // frame sequencing; a rise always wins over a same-cycle breakdown
  always_comb begin
    state_nx = S_IDLE;
    if (monitor_en)
      case (state)
        S_IDLE:   state_nx = fall ? S_WAIT : S_IDLE;
        S_WAIT:   state_nx = rise ? S_REPORT : bd ? S_ON : S_WAIT;
        S_ON:     state_nx = rise ? S_REPORT : S_ON;
        S_REPORT: state_nx = fall ? S_WAIT : S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
  end
  // input registers, state and per-frame measurements
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      deion_d <= 1'b0;
      cur_d   <= '0;
      vol_d   <= '0;
      state   <= S_IDLE;
      dly     <= '0;
      ont     <= '0;
      peak    <= '0;
      v_bd    <= '0;
      ptype   <= PT_OPEN;
    end else begin
      deion_d <= mosfet_deion;
      cur_d   <= sample_current;
      vol_d   <= sample_voltage;
      state   <= state_nx;
      if (fall) dly <= '0;
      else if (state == S_WAIT && (rise || !bd)) dly <= sat_inc(dly);
      if (fall || (state == S_WAIT && bd)) ont <= '0;
      else if (state == S_ON) ont <= sat_inc(ont);
      if (fall) peak <= '0;
      else if (state == S_ON && !cur_d[16] && cur_d[15:0] > peak) peak <= cur_d[15:0];
      if (state == S_WAIT && bd) v_bd <= vol_d;
      if (state == S_WAIT && rise) ptype <= PT_OPEN;
      else if (state == S_ON && rise) ptype <= cls;
    end
  // report strobe and held report fields
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pulse_valid    <= 1'b0;
      pulse_type     <= '0;
      ignition_delay <= '0;
      on_time        <= '0;
      peak_current   <= '0;
    end else begin
      pulse_valid <= rep;
      if (rep) begin
        pulse_type     <= ptype;
        ignition_delay <= dly;
        on_time        <= ont;
        peak_current   <= peak;
      end
    end
  sat_counter16 u_cnt_open   (.clk(clk), .rst_n(rst_n), .clr(stat_clear), .inc(pulse_valid && pulse_type == PT_OPEN),   .cnt(cnt_open));
  sat_counter16 u_cnt_normal (.clk(clk), .rst_n(rst_n), .clr(stat_clear), .inc(pulse_valid && pulse_type == PT_NORMAL), .cnt(cnt_normal));
  sat_counter16 u_cnt_arc    (.clk(clk), .rst_n(rst_n), .clr(stat_clear), .inc(pulse_valid && pulse_type == PT_ARC),    .cnt(cnt_arc));
  sat_counter16 u_cnt_short  (.clk(clk), .rst_n(rst_n), .clr(stat_clear), .inc(pulse_valid && pulse_type == PT_SHORT),  .cnt(cnt_short));
endmodule
